// File: rtl/glyph_blitter.sv
// Copies one rectangular glyph from a synchronous sprite ROM into the frame buffer,
// one pixel per clock, skipping transparent pixels and clipping to the frame.
module glyph_blitter #(
  parameter int SHEET_W = 160,
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int PIX_W   = 12,
  parameter logic [PIX_W-1:0] KEY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       src_h,
  input  logic [6:0]       src_v,
  input  logic [7:0]       dst_h,
  input  logic [6:0]       dst_v,
  input  logic [5:0]       width,
  input  logic [5:0]       height,
  output logic             busy,
  output logic             done,
  output logic [15:0]      rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic             fb_we,
  output logic [14:0]      fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  src_h_q, src_h_d;
  logic [6:0]  src_v_q, src_v_d;
  logic [7:0]  dst_h_q, dst_h_d;
  logic [6:0]  dst_v_q, dst_v_d;
  logic [5:0]  width_q, width_d;
  logic [5:0]  height_q, height_d;
  logic [5:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic        valid_q, valid_d;
  logic [8:0]  dx_q, dx_d;
  logic [7:0]  dy_q, dy_d;
  logic [14:0] fb_addr_q, fb_addr_d;

  logic [15:0] rom_lin;
  logic [8:0]  cur_dx;
  logic [7:0]  cur_dy;

  // Destination coordinates are one bit wider than the inputs so that
  // glyphs running off the right/bottom edge clip instead of wrapping.
  assign cur_dx  = {1'b0, dst_h_q} + 9'(x_q);
  assign cur_dy  = {1'b0, dst_v_q} + 8'(y_q);
  assign rom_lin = 16'((32'(src_v_q) + 32'(y_q)) * SHEET_W + 32'(src_h_q) + 32'(x_q));

  always_comb begin
    state_d   = state_q;
    src_h_d   = src_h_q;
    src_v_d   = src_v_q;
    dst_h_d   = dst_h_q;
    dst_v_d   = dst_v_q;
    width_d   = width_q;
    height_d  = height_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    dx_d      = dx_q;
    dy_d      = dy_q;
    fb_addr_d = fb_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_h_d  = src_h;
          src_v_d  = src_v;
          dst_h_d  = dst_h;
          dst_v_d  = dst_v;
          width_d  = width;
          height_d = height;
          x_d      = '0;
          y_d      = '0;
          state_d  = (width == 6'd0 || height == 6'd0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        valid_d   = 1'b1;
        dx_d      = cur_dx;
        dy_d      = cur_dy;
        fb_addr_d = 15'(32'(cur_dy) * FB_W + 32'(cur_dx));
        if (x_q == width_q - 6'd1) begin
          x_d = '0;
          if (y_q == height_q - 6'd1) state_d = S_DRAIN;
          else y_d = y_q + 6'd1;
        end else begin
          x_d = x_q + 6'd1;
        end
      end
      S_DRAIN: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_h_q   <= '0;
      src_v_q   <= '0;
      dst_h_q   <= '0;
      dst_v_q   <= '0;
      width_q   <= '0;
      height_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      fb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      src_h_q   <= src_h_d;
      src_v_q   <= src_v_d;
      dst_h_q   <= dst_h_d;
      dst_v_q   <= dst_v_d;
      width_q   <= width_d;
      height_q  <= height_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      fb_addr_q <= fb_addr_d;
    end
  end

  // Write stage sees the ROM word for the pixel captured in the pipeline register.
  assign fb_we     = valid_q && (rom_data != KEY) && (32'(dx_q) < FB_W) && (32'(dy_q) < FB_H);
  assign fb_addr   = fb_addr_q;
  assign fb_data   = rom_data;
  assign rom_addr  = (state_q == S_RUN) ? rom_lin : '0;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);
  assign dbg_state = state_q;

endmodule

// File: doc/glyph_blitter.md
Name: glyph_blitter

Overview:
- Sequential writer that copies one rectangular glyph from the sprite-sheet ROM into the frame-buffer RAM.
- The VGA scan path later reads that frame buffer out pixel-by-pixel, so this block is the write side of the scene-rendering data path.
- A scene controller issues one start per glyph (e.g. "L","O","S","S" of the fail screen), with source and destination rectangles.
- Throughput is one pixel per clock. Pixels matching the transparent key are skipped. Writes falling outside the frame buffer are clipped.

Parameters:
- SHEET_W, 160, sprite-sheet row pitch in pixels.
- FB_W, 160, frame-buffer width in pixels.
- FB_H, 120, frame-buffer height in pixels.
- PIX_W, 12, pixel width (4:4:4 RGB).
- KEY, 12'h000, transparent colour; never written.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_h  in  8  glyph left column in the sheet.
- src_v  in  7  glyph top row in the sheet.
- dst_h  in  8  destination left column.
- dst_v  in  7  destination top row.
- width  in  6  glyph width in pixels, 0..63.
- height  in  6  glyph height in pixels, 0..63.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at completion.
- rom_addr  out  16  sprite ROM address; ROM is synchronous, 1-cycle read latency.
- rom_data  in  12  ROM output, valid the cycle after rom_addr.
- fb_we  out  1  frame-buffer write enable.
- fb_addr  out  15  frame-buffer address = y*FB_W + x.
- fb_data  out  12  write data.

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0; all counters 0. Reset mid-copy aborts immediately with no further writes and no done pulse.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - On start=1, latch src_h, src_v, dst_h, dst_v, width, height.
  - Clear x=0, y=0.
  - Go to RUN, or directly to FIN if width==0 or height==0. In that case no ROM read and no write occur.
- RUN (one pixel per cycle):
  - rom_addr = (src_v+y)*SHEET_W + src_h + x, computed in 17 bits and truncated to 16.
  - Pipeline register captures {valid=1, dx=dst_h+x, dy=dst_v+y} for the next cycle.
  - x increments each cycle. When x==width-1: x<=0 and y increments.
  - When x==width-1 and y==height-1, go to DRAIN.
- DRAIN: one cycle; the last pipeline entry is written. Then go to FIN.
- FIN: done=1 for exactly one cycle; busy=0 in this cycle; return to IDLE.
- Write stage (cycle after each RUN cycle):
  - fb_we = valid && rom_data!=KEY && dx<FB_W && dy<FB_H. fb_we is combinational from the pipeline register and rom_data.
  - fb_addr = dy*FB_W + dx, registered alongside valid.
  - fb_data = rom_data.
- Latency: for start accepted at edge k and N = width*height:
  - busy=1 in cycles k+1..k+N+1.
  - First ROM address in cycle k+1; first possible fb_we in cycle k+2.
  - Last fb_we in cycle k+N+1; done in cycle k+N+2.
- start while busy or in FIN is ignored and not queued.
- Input changes after acceptance have no effect; values are latched at start.
- dx/dy are computed 9/8 bits wide, so destinations wrapping past 255/127 are clipped, not wrapped.
- Never more than one write per cycle. No write ever targets an address ≥ FB_W*FB_H.

Test Plan:
- Basic copy: src=(55,50), dst=(70,60), 23x40, ROM data = address low 12 bits, all nonzero.
  - Exactly 920 fb_we pulses.
  - First write fb_addr=60*160+70=9670, data=(50*160+55)&12'hFFF.
  - done at start+922 cycles.
- Transparency: 4x4 glyph whose ROM returns 12'h000 on the diagonal.
  - 12 writes; the 4 diagonal fb addresses are never written.
- Clipping: dst=(150,115), 23x40.
  - Only the region x<160, y<120 is written: 10*5=50 writes.
  - busy still lasts 921 cycles.
- Zero size: width=0, height=7.
  - busy never asserts; done one cycle after start; no ROM or FB activity.
- Back-to-back glyphs: start pulses during busy are ignored.
  - A start in the cycle after done is accepted.
  - Four "L","O","S","S" glyphs produce 920+1000+920+920 writes total.
- Reset mid-copy: assert rst at pixel 100 of a 23x40 copy.
  - Outputs are 0 immediately and fb_we never rises again.
  - No done pulse.
  - A fresh start after reset release runs normally.
